// File: rtl/unidade_muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit, its decoder and the
// register-file write mux.
package pkg_muldiv;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = $clog2(XLEN);

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIM  = 2'd2
    } state_t;

endpackage

// File: rtl/unidade_muldiv.sv
// Iterative radix-2 multiply/divide unit: sign-magnitude operands, one shared
// 33-bit adder and a 64-bit shift register, fixed 34-cycle latency.
module unidade_muldiv
    import pkg_muldiv::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned DW = 2 * XLEN;
    localparam int unsigned AW = XLEN + 1;

    function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [DW-1:0] neg_d(input logic [DW-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    state_t            state_q, state_d;
    logic [2:0]        f3_q, f3_d;
    logic              neg_q, neg_d_r;
    logic              sa_q, sa_d;
    logic              zero_q, zero_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [DW-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              a_signed, b_signed, sa_in, sb_in, is_div, no_borrow;
    logic [XLEN-1:0]   hi, lo, add_a, add_b, quot, rem, sel;
    logic [AW-1:0]     sum;
    logic [DW-1:0]     acc_step, prod;

    // Operand signedness of the incoming request
    always_comb begin
        a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                   (funct3 == F3_DIV)  || (funct3 == F3_REM);
        b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
        sa_in    = a_signed & op_a[XLEN-1];
        sb_in    = b_signed & op_b[XLEN-1];
    end

    // Shared adder: add multiplicand, or trial-subtract divisor from shifted remainder
    always_comb begin
        is_div    = f3_q[2];
        hi        = acc_q[DW-1:XLEN];
        lo        = acc_q[XLEN-1:0];
        add_a     = is_div ? {hi[XLEN-2:0], lo[XLEN-1]} : hi;
        add_b     = is_div ? ~opb_q : opb_q;
        sum       = {1'b0, add_a} + {1'b0, add_b} + AW'(is_div);
        // A set top bit in rem means the shifted value already exceeds any divisor
        no_borrow = sum[XLEN] | hi[XLEN-1];
        if (is_div) begin
            acc_step = no_borrow ? {sum[XLEN-1:0], lo[XLEN-2:0], 1'b1}
                                 : {add_a, lo[XLEN-2:0], 1'b0};
        end else begin
            acc_step = lo[0] ? {sum, lo[XLEN-1:1]} : {1'b0, hi, lo[XLEN-1:1]};
        end
    end

    // Sign fixup and result selection
    always_comb begin
        prod = neg_d(acc_q, neg_q);
        quot = zero_q ? '1 : neg_w(lo, neg_q);
        rem  = neg_w(hi, sa_q);
        case (f3_q)
            F3_MUL:                       sel = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: sel = prod[DW-1:XLEN];
            F3_DIV, F3_DIVU:              sel = quot;
            default:                      sel = rem;
        endcase
    end

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        f3_d     = f3_q;
        neg_d_r  = neg_q;
        sa_d     = sa_q;
        zero_d   = zero_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    f3_d    = funct3;
                    neg_d_r = sa_in ^ sb_in;
                    sa_d    = sa_in;
                    zero_d  = (op_b == '0);
                    opb_d   = neg_w(op_b, sb_in);
                    acc_d   = {{XLEN{1'b0}}, neg_w(op_a, sa_in)};
                    cnt_d   = CNT_W'(XLEN - 1);
                    busy_d  = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                acc_d  = acc_step;
                cnt_d  = cnt_q - CNT_W'(1);
                busy_d = 1'b1;
                if (cnt_q == '0) state_d = S_FIM;
            end
            S_FIM: begin
                result_d = sel;
                done_d   = 1'b1;
                busy_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            sa_q     <= 1'b0;
            zero_q   <= 1'b0;
            opb_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d_r;
            sa_q     <= sa_d;
            zero_q   <= zero_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
